audio_byte_fifo: RTL and testbench



---
 rtl/audio_byte_fifo.sv | 87 ++++++++
 tb/tb_audio_byte_fifo.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/audio_byte_fifo.sv
// audio_byte_fifo
//   Single-clock, first-word-fall-through FIFO that sits between the host-side
//   byte writer and the I2S sample assembler. The head entry is always visible
//   on rd_data_o, so a consumer holding rd_en_i high pops one byte per clock.
//
// Ports
//   clk_i        : clock; all state updates on its rising edge
//   reset_i      : asynchronous, active-high; clears pointers and occupancy
//   wr_en_i      : write request, accepted only while wr_full_o is low
//   wr_data_i    : byte stored on an accepted write
//   wr_awfull_o  : almost full, occupancy >= DEPTH-1
//   wr_full_o    : occupancy == DEPTH
//   rd_en_i      : pop request, accepted only while rd_empty_o is low
//   rd_data_o    : current head entry (don't-care while rd_empty_o is high)
//   rd_empty_o   : occupancy == 0
module audio_byte_fifo #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             wr_en_i,
  input  logic [DSIZE-1:0] wr_data_i,
  output logic             wr_awfull_o,
  output logic             wr_full_o,
  input  logic             rd_en_i,
  output logic [DSIZE-1:0] rd_data_o,
  output logic             rd_empty_o
);

  localparam int DEPTH = 1 << ASIZE;

  // Occupancy thresholds expressed in the ASIZE+1 bit count domain.
  localparam logic [ASIZE:0] FULL_CNT  = {1'b1, {ASIZE{1'b0}}};
  localparam logic [ASIZE:0] AFULL_CNT = {1'b0, {ASIZE{1'b1}}};

  logic [DSIZE-1:0] mem_q [DEPTH];

  logic [ASIZE-1:0] wptr_q, wptr_d;
  logic [ASIZE-1:0] rptr_q, rptr_d;
  logic [ASIZE:0]   cnt_q,  cnt_d;
  logic             wr_acc;
  logic             rd_acc;

  // Acceptance uses the registered flags, so a full FIFO with both requests
  // active only pops, and an empty FIFO with both requests active only pushes.
  always_comb begin
    wr_acc = wr_en_i & ~wr_full_o;
    rd_acc = rd_en_i & ~rd_empty_o;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (wr_acc) wptr_d = wptr_q + 1'b1;
    if (rd_acc) rptr_d = rptr_q + 1'b1;
    case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage carries no reset; stale contents are unreachable once the
  // pointers and count are cleared.
  always_ff @(posedge clk_i) begin
    if (wr_acc) mem_q[wptr_q] <= wr_data_i;
  end

  // Fall-through read: head entry is presented combinationally.
  assign rd_data_o = mem_q[rptr_q];

  assign rd_empty_o  = (cnt_q == '0);
  assign wr_full_o   = (cnt_q == FULL_CNT);
  assign wr_awfull_o = (cnt_q >= AFULL_CNT);

endmodule

// File: tb/tb_audio_byte_fifo.sv
module tb_audio_byte_fifo;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       wr_en_i;
  logic [7:0] wr_data_i;
  logic       wr_awfull_o;
  logic       wr_full_o;
  logic       rd_en_i;
  logic [7:0] rd_data_o;
  logic       rd_empty_o;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [7:0] sb_q[$];  // bytes expected to come out, oldest first

  audio_byte_fifo #(.DSIZE(8), .ASIZE(4)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .wr_en_i     (wr_en_i),
    .wr_data_i   (wr_data_i),
    .wr_awfull_o (wr_awfull_o),
    .wr_full_o   (wr_full_o),
    .rd_en_i     (rd_en_i),
    .rd_data_o   (rd_data_o),
    .rd_empty_o  (rd_empty_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Flags and head value against the scoreboard occupancy.
  task automatic chk_state(input string tag);
    int n;
    n = sb_q.size();
    chk({tag, ".empty"},  {31'd0, rd_empty_o},  {31'd0, n == 0});
    chk({tag, ".full"},   {31'd0, wr_full_o},   {31'd0, n == 16});
    chk({tag, ".awfull"}, {31'd0, wr_awfull_o}, {31'd0, n >= 15});
    if (n > 0) chk({tag, ".head"}, {24'd0, rd_data_o}, {24'd0, sb_q[0]});
  endtask

  // One clock: drive requests, predict acceptance from pre-edge occupancy,
  // check the popped byte before the edge and the state after it.
  task automatic step(input logic wr, input logic [7:0] d, input logic rd, input string tag);
    logic wr_acc, rd_acc;
    logic [7:0] exp_b;
    wr_en_i   = wr;
    wr_data_i = d;
    rd_en_i   = rd;
    wr_acc = wr && (sb_q.size() != 16);
    rd_acc = rd && (sb_q.size() != 0);
    if (rd_acc) begin
      exp_b = sb_q.pop_front();
      chk({tag, ".pop"}, {24'd0, rd_data_o}, {24'd0, exp_b});
    end
    if (wr_acc) sb_q.push_back(d);
    @(posedge clk_i);
    #1;
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    chk_state(tag);
    $display("step %-10s wr=%0b d=%02h rd=%0b -> occ=%0d empty=%0b awfull=%0b full=%0b head=%02h",
             tag, wr, d, rd, sb_q.size(), rd_empty_o, wr_awfull_o, wr_full_o, rd_data_o);
  endtask

  task automatic pulse_reset(input string tag);
    #3 reset_i = 1'b1;
    #1;
    sb_q.delete();
    chk_state({tag, ".async"});
    @(posedge clk_i);
    #1 reset_i = 1'b0;
    chk_state({tag, ".rel"});
    $display("reset %s", tag);
  endtask

  initial begin
    reset_i   = 1'b1;
    wr_en_i   = 1'b0;
    wr_data_i = '0;
    rd_en_i   = 1'b0;
    #1;
    chk_state("por");
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;

    // Reset asserted mid-clock, then first write lands at entry 0.
    step(1'b1, 8'h11, 1'b0, "pre");
    pulse_reset("rst1");
    step(1'b1, 8'hA5, 1'b0, "a5");
    step(1'b0, 8'h00, 1'b1, "a5rd");

    // Fill with 0x00..0x0F, overflow write dropped, drain in order.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, "fill");
    step(1'b1, 8'hFF, 1'b0, "ovf");
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, "drain");

    // Three entries, five reads: extra reads are ignored.
    for (int i = 0; i < 3; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, "w3");
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, "r5");
    step(1'b1, 8'h42, 1'b0, "after_r5");
    step(1'b0, 8'h00, 1'b1, "after_r5");

    // Full with both active: read only, write dropped.
    for (int i = 0; i < 16; i++) step(1'b1, 8'h80 + 8'(i), 1'b0, "fill2");
    step(1'b1, 8'h77, 1'b1, "full_rw");
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1, "drain2");

    // Empty with both active: write only.
    step(1'b1, 8'h55, 1'b1, "empty_rw");
    step(1'b0, 8'h00, 1'b1, "empty_rd");

    // Occupancy 8 with both active for 20 cycles.
    for (int i = 0; i < 8; i++) step(1'b1, 8'h20 + 8'(i), 1'b0, "w8");
    for (int i = 0; i < 20; i++) step(1'b1, 8'h40 + 8'(i), 1'b1, "rw8");
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, "d8");

    // Streaming across pointer wrap: writer two ahead of reader.
    step(1'b1, 8'd0, 1'b0, "strm");
    step(1'b1, 8'd1, 1'b0, "strm");
    for (int i = 2; i < 100; i++) step(1'b1, 8'(i), 1'b1, "strm");
    step(1'b0, 8'h00, 1'b1, "strm");
    step(1'b0, 8'h00, 1'b1, "strm");

    // Reset with data queued discards everything.
    for (int i = 0; i < 10; i++) step(1'b1, 8'hE0 + 8'(i), 1'b0, "q10");
    pulse_reset("rst2");
    step(1'b1, 8'h3C, 1'b0, "w3c");
    step(1'b0, 8'h00, 1'b1, "r3c");
    step(1'b0, 8'h00, 1'b1, "r3c_x");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
